// File: rtl/iq_scan_pkg.sv
// ============================================================================
// Module      : iq_scan_pkg
// Description : Shared definitions for the IQ channel-scan controller: the
//               scan state enumeration, the power-metric width function and
//               the |I|+|Q| metric helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package iq_scan_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TUNE    = 3'd1,
        S_MEASURE = 3'd2,
        S_COMPARE = 3'd3,
        S_LOCK    = 3'd4
    } scan_state_t;

    // Width that holds MEAS_SAMPLES metrics of (|I|+|Q|) without overflow:
    // one sample metric needs SAMPLE_WIDTH+1 bits (2 * 2^(SW-1) = 2^SW).
    function automatic int calc_acc_w(input int sample_width, input int meas_samples);
        return sample_width + 1 + $clog2(meas_samples);
    endfunction

    // Magnitude of a sign-extended sample. The most negative sample value
    // maps to its true magnitude because the operand is wider than a sample.
    function automatic logic [31:0] iq_abs(input logic signed [31:0] x);
        return (x < 0) ? 32'(-x) : 32'(x);
    endfunction

    function automatic logic [31:0] iq_metric(input logic signed [31:0] i_val,
                                              input logic signed [31:0] q_val);
        return iq_abs(i_val) + iq_abs(q_val);
    endfunction

endpackage

`default_nettype wire

// File: rtl/iq_scan_ctrl_if.sv
// ============================================================================
// Module      : iq_scan_ctrl_if
// Description : Control / sample / result bundle of the IQ scan controller.
//               master : request and sample source (drives start, abort,
//                        sample_valid, i_in, q_in)
//               slave  : the controller (drives lo_fre, busy, done,
//                        lock_valid, best_ch, best_pwr)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface iq_scan_ctrl_if #(
    parameter int PH_BITS      = 32,
    parameter int SAMPLE_WIDTH = 12,
    parameter int CH_W         = 4,
    parameter int ACC_W        = 19
);
    logic                           start;
    logic                           abort;
    logic                           sample_valid;
    logic signed [SAMPLE_WIDTH-1:0] i_in;
    logic signed [SAMPLE_WIDTH-1:0] q_in;
    logic [PH_BITS-1:0]             lo_fre;
    logic                           busy;
    logic                           done;
    logic                           lock_valid;
    logic [CH_W-1:0]                best_ch;
    logic [ACC_W-1:0]               best_pwr;

    modport master (
        output start, abort, sample_valid, i_in, q_in,
        input  lo_fre, busy, done, lock_valid, best_ch, best_pwr
    );

    modport slave (
        input  start, abort, sample_valid, i_in, q_in,
        output lo_fre, busy, done, lock_valid, best_ch, best_pwr
    );
endinterface

`default_nettype wire

// File: rtl/iq_pwr_acc.sv
// ============================================================================
// Module      : iq_pwr_acc
// Description : Power accumulator. While i_en is high every valid sample adds
//               |I|+|Q| to the running sum; o_last flags the sample that
//               completes a window of MEAS_SAMPLES. i_clr zeroes sum and count
//               and has priority over accumulation.
// Ports       : clk_in, RST (async active-low), i_clr, i_en, i_valid,
//               i_i, i_q (signed samples), o_acc (registered sum),
//               o_last (window-completing sample accepted this cycle),
//               o_sum (sum including the current sample; only with
//               IQ_SCAN_SQUELCH_EN defined)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iq_pwr_acc
    import iq_scan_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 12,
    parameter int MEAS_SAMPLES = 64,
    parameter int ACC_W        = calc_acc_w(SAMPLE_WIDTH, MEAS_SAMPLES)
) (
    input  wire logic                           clk_in,
    input  wire logic                           RST,
    input  wire logic                           i_clr,
    input  wire logic                           i_en,
    input  wire logic                           i_valid,
    input  wire logic signed [SAMPLE_WIDTH-1:0] i_i,
    input  wire logic signed [SAMPLE_WIDTH-1:0] i_q,
`ifdef IQ_SCAN_SQUELCH_EN
    output logic [ACC_W-1:0]                    o_sum,
`endif
    output logic [ACC_W-1:0]                    o_acc,
    output logic                                o_last
);

    localparam int CNT_W = $clog2(MEAS_SAMPLES);

    logic signed [31:0] w_i_ext;
    logic signed [31:0] w_q_ext;
    logic [ACC_W-1:0]   w_metric;
    logic [ACC_W-1:0]   w_sum;
    logic               w_take;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;

    assign w_i_ext  = {{(32-SAMPLE_WIDTH){i_i[SAMPLE_WIDTH-1]}}, i_i};
    assign w_q_ext  = {{(32-SAMPLE_WIDTH){i_q[SAMPLE_WIDTH-1]}}, i_q};
    assign w_metric = ACC_W'(iq_metric(w_i_ext, w_q_ext));
    assign w_sum    = r_acc + w_metric;
    assign w_take   = i_en & i_valid;
    assign o_last   = w_take && (r_cnt == CNT_W'(MEAS_SAMPLES - 1));
    assign o_acc    = r_acc;
`ifdef IQ_SCAN_SQUELCH_EN
    assign o_sum    = w_sum;
`endif

    // MEAS_SAMPLES is a power of two, so the count wraps to zero by itself
    // after the window-completing sample.
    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_take) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/iq_scan_ctrl.sv
// ============================================================================
// Module      : iq_scan_ctrl
// Description : Channel scanner. Steps the LO over CH_NUM channels, lets each
//               retune settle, accumulates |I|+|Q| over MEAS_SAMPLES valid
//               samples, keeps the strongest channel (lowest index on ties)
//               and finally retunes the LO to it and reports lock.
//               Optional macro IQ_SCAN_SQUELCH_EN: while locked, the locked
//               channel is re-measured in back-to-back windows and a run of
//               SQ_WINDOWS windows below SQ_THRESH restarts the scan.
// Ports       : clk_in  - clock, rising edge
//               RST     - asynchronous active-low reset
//               bus     - iq_scan_ctrl_if.slave (start, abort, sample_valid,
//                         i_in, q_in in; lo_fre, busy, done, lock_valid,
//                         best_ch, best_pwr out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iq_scan_ctrl
    import iq_scan_pkg::*;
#(
    parameter int                 CH_NUM        = 16,
    parameter int                 PH_BITS       = 32,
    parameter int                 SAMPLE_WIDTH  = 12,
    parameter logic [PH_BITS-1:0] START_FRE     = PH_BITS'(0),
    parameter logic [PH_BITS-1:0] STEP_FRE      = PH_BITS'(1000),
    parameter int                 SETTLE_CYCLES = 1024,
    parameter int                 MEAS_SAMPLES  = 64
`ifdef IQ_SCAN_SQUELCH_EN
    ,
    parameter logic [calc_acc_w(SAMPLE_WIDTH, MEAS_SAMPLES)-1:0] SQ_THRESH = '0,
    parameter int                 SQ_WINDOWS    = 4
`endif
) (
    input  wire logic     clk_in,
    input  wire logic     RST,
    iq_scan_ctrl_if.slave bus
);

    localparam int CH_W  = $clog2(CH_NUM);
    localparam int ACC_W = calc_acc_w(SAMPLE_WIDTH, MEAS_SAMPLES);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
`ifdef IQ_SCAN_SQUELCH_EN
    localparam int SQC_W = $clog2(SQ_WINDOWS + 1);
`endif

    scan_state_t        r_state, w_state_nxt;
    logic [CH_W-1:0]    r_ch, w_ch_nxt;
    logic [CH_W-1:0]    r_best_ch, w_best_ch_nxt;
    logic [ACC_W-1:0]   r_best_pwr, w_best_pwr_nxt;
    logic [PH_BITS-1:0] r_lo, w_lo_nxt;
    logic [SET_W-1:0]   r_settle, w_settle_nxt;
    logic               r_done, w_done_nxt;
    logic               w_fresh;
    logic               w_better;
    logic               w_acc_clr;
    logic               w_acc_en;
    logic               w_acc_last;
    logic [ACC_W-1:0]   w_acc;
`ifdef IQ_SCAN_SQUELCH_EN
    logic [ACC_W-1:0]   w_acc_sum;
    logic [SQC_W-1:0]   r_sq_cnt, w_sq_cnt_nxt;
`endif

    // LO word for a channel, wrapping modulo 2^PH_BITS.
    function automatic logic [PH_BITS-1:0] lo_of(input logic [CH_W-1:0] ch);
        return START_FRE + PH_BITS'(ch) * STEP_FRE;
    endfunction

    iq_pwr_acc #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .MEAS_SAMPLES (MEAS_SAMPLES),
        .ACC_W        (ACC_W)
    ) u_acc (
        .clk_in  (clk_in),
        .RST     (RST),
        .i_clr   (w_acc_clr),
        .i_en    (w_acc_en),
        .i_valid (bus.sample_valid),
        .i_i     (bus.i_in),
        .i_q     (bus.q_in),
`ifdef IQ_SCAN_SQUELCH_EN
        .o_sum   (w_acc_sum),
`endif
        .o_acc   (w_acc),
        .o_last  (w_acc_last)
    );

    // Strict compare: on a tie the earlier (lower) channel is kept.
    assign w_better = (w_acc > r_best_pwr);

    always_comb begin
        w_state_nxt    = r_state;
        w_ch_nxt       = r_ch;
        w_best_ch_nxt  = r_best_ch;
        w_best_pwr_nxt = r_best_pwr;
        w_lo_nxt       = r_lo;
        w_settle_nxt   = r_settle;
        w_done_nxt     = 1'b0;
        w_acc_clr      = 1'b0;
        w_acc_en       = 1'b0;
        w_fresh        = 1'b0;
`ifdef IQ_SCAN_SQUELCH_EN
        w_sq_cnt_nxt   = r_sq_cnt;
`endif

        case (r_state)
            S_IDLE: begin
                w_fresh = bus.start;
            end

            S_TUNE: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_settle == SET_W'(SETTLE_CYCLES - 1)) begin
                    w_state_nxt  = S_MEASURE;
                    w_settle_nxt = '0;
                end else begin
                    w_settle_nxt = r_settle + SET_W'(1);
                end
            end

            S_MEASURE: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_acc_en = 1'b1;
                    if (w_acc_last) begin
                        w_state_nxt = S_COMPARE;
                    end
                end
            end

            S_COMPARE: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    if (w_better) begin
                        w_best_pwr_nxt = w_acc;
                        w_best_ch_nxt  = r_ch;
                    end
                    if (r_ch == CH_W'(CH_NUM - 1)) begin
                        w_state_nxt = S_LOCK;
                        w_lo_nxt    = lo_of(w_best_ch_nxt);
                        w_done_nxt  = 1'b1;
`ifdef IQ_SCAN_SQUELCH_EN
                        w_acc_clr    = 1'b1;
                        w_sq_cnt_nxt = '0;
`endif
                    end else begin
                        w_ch_nxt     = r_ch + CH_W'(1);
                        w_state_nxt  = S_TUNE;
                        w_lo_nxt     = lo_of(w_ch_nxt);
                        w_acc_clr    = 1'b1;
                        w_settle_nxt = '0;
                    end
                end
            end

            S_LOCK: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.start) begin
                    w_fresh = 1'b1;
                end else begin
`ifdef IQ_SCAN_SQUELCH_EN
                    // Windows run back to back: the accumulator is cleared on
                    // the edge that completes a window, and that window's
                    // total is judged from the combinational sum.
                    w_acc_en = 1'b1;
                    if (w_acc_last) begin
                        w_acc_clr = 1'b1;
                        if (w_acc_sum < SQ_THRESH) begin
                            if (r_sq_cnt == SQC_W'(SQ_WINDOWS - 1)) begin
                                w_fresh = 1'b1;
                            end else begin
                                w_sq_cnt_nxt = r_sq_cnt + SQC_W'(1);
                            end
                        end else begin
                            w_sq_cnt_nxt = '0;
                        end
                    end
`endif
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // New scan from channel 0 with the best-so-far result cleared.
        if (w_fresh) begin
            w_state_nxt    = S_TUNE;
            w_ch_nxt       = '0;
            w_best_ch_nxt  = '0;
            w_best_pwr_nxt = '0;
            w_lo_nxt       = START_FRE;
            w_settle_nxt   = '0;
            w_acc_clr      = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            r_ch       <= '0;
            r_best_ch  <= '0;
            r_best_pwr <= '0;
            r_lo       <= START_FRE;
            r_settle   <= '0;
            r_done     <= 1'b0;
`ifdef IQ_SCAN_SQUELCH_EN
            r_sq_cnt   <= '0;
`endif
        end else begin
            r_ch       <= w_ch_nxt;
            r_best_ch  <= w_best_ch_nxt;
            r_best_pwr <= w_best_pwr_nxt;
            r_lo       <= w_lo_nxt;
            r_settle   <= w_settle_nxt;
            r_done     <= w_done_nxt;
`ifdef IQ_SCAN_SQUELCH_EN
            r_sq_cnt   <= w_sq_cnt_nxt;
`endif
        end
    end

    assign bus.lo_fre     = r_lo;
    assign bus.busy       = (r_state == S_TUNE) || (r_state == S_MEASURE) ||
                            (r_state == S_COMPARE);
    assign bus.done       = r_done;
    assign bus.lock_valid = (r_state == S_LOCK);
    assign bus.best_ch    = r_best_ch;
    assign bus.best_pwr   = r_best_pwr;

endmodule

`default_nettype wire

// File: tb/tb_iq_scan_ctrl.sv
// ============================================================================
// Module      : tb_iq_scan_ctrl
// Description : Self-checking bench for iq_scan_ctrl (CH_NUM=4, START=1000,
//               STEP=100, SETTLE=8, MEAS=4, SAMPLE_WIDTH=12). A behavioural
//               scan model tracks the expected outputs; a compare process
//               checks every cycle, and directed scenarios pin literal
//               results. With IQ_SCAN_SQUELCH_EN the squelch rescan is also
//               exercised (SQ_THRESH=100, SQ_WINDOWS=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iq_scan_ctrl;
    import iq_scan_pkg::*;

    localparam int CH_NUM = 4;
    localparam int PH_BITS = 32;
    localparam int SW = 12;
    localparam int SETTLE = 8;
    localparam int MEAS = 4;
    localparam int START = 1000;
    localparam int STEP = 100;
    localparam int CH_W = $clog2(CH_NUM);
    localparam int ACC_W = calc_acc_w(SW, MEAS);
`ifdef IQ_SCAN_SQUELCH_EN
    localparam int SQ_TH = 100;
    localparam int SQ_WIN = 2;
`endif

    logic clk_in = 1'b0;
    logic RST;
    always #5 clk_in = ~clk_in;

    iq_scan_ctrl_if #(.PH_BITS(PH_BITS), .SAMPLE_WIDTH(SW), .CH_W(CH_W), .ACC_W(ACC_W)) bus ();

    iq_scan_ctrl #(
        .CH_NUM        (CH_NUM),
        .PH_BITS       (PH_BITS),
        .SAMPLE_WIDTH  (SW),
        .START_FRE     (32'(START)),
        .STEP_FRE      (32'(STEP)),
        .SETTLE_CYCLES (SETTLE),
        .MEAS_SAMPLES  (MEAS)
`ifdef IQ_SCAN_SQUELCH_EN
        ,
        .SQ_THRESH     (ACC_W'(SQ_TH)),
        .SQ_WINDOWS    (SQ_WIN)
`endif
    ) dut (
        .clk_in (clk_in),
        .RST    (RST),
        .bus    (bus)
    );

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Model: mode 0 idle, 1 settling, 2 measuring, 3 comparing, 4 locked.
    int m_mode, m_cnt, m_ch, m_lo, m_bc, m_bp;
    int m_sum [CH_NUM];
    bit m_done;
    int m_wsum, m_wcnt, m_low;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic model_fresh();
        m_mode = 1; m_ch = 0; m_cnt = 0;
        for (int k = 0; k < CH_NUM; k++) m_sum[k] = 0;
        m_bp = 0; m_bc = 0; m_lo = START;
    endtask

    task automatic model_reset();
        model_fresh();
        m_mode = 0; m_done = 1'b0;
        m_wsum = 0; m_wcnt = 0; m_low = 0;
    endtask

    task automatic model_step(input bit s, input bit a, input bit v, input int i, input int q);
        m_done = 1'b0;
        if (a && m_mode != 0) begin
            m_mode = 0;
            return;
        end
        case (m_mode)
            0: if (s) model_fresh();
            1: begin
                m_cnt++;
                if (m_cnt == SETTLE) begin m_mode = 2; m_cnt = 0; end
            end
            2: if (v) begin
                m_sum[m_ch] += iabs(i) + iabs(q);
                m_cnt++;
                if (m_cnt == MEAS) m_mode = 3;
            end
            3: begin
                // Best over every channel measured so far; first maximum wins.
                m_bp = 0; m_bc = 0;
                for (int k = 0; k <= m_ch; k++)
                    if (m_sum[k] > m_bp) begin m_bp = m_sum[k]; m_bc = k; end
                if (m_ch == CH_NUM - 1) begin
                    m_mode = 4; m_lo = START + m_bc * STEP; m_done = 1'b1;
                    m_wsum = 0; m_wcnt = 0; m_low = 0;
                end else begin
                    m_ch++; m_mode = 1; m_cnt = 0; m_lo = START + m_ch * STEP;
                end
            end
            4: begin
                if (s) model_fresh();
`ifdef IQ_SCAN_SQUELCH_EN
                else if (v) begin
                    m_wsum += iabs(i) + iabs(q);
                    m_wcnt++;
                    if (m_wcnt == MEAS) begin
                        if (m_wsum < SQ_TH) begin
                            m_low++;
                            if (m_low == SQ_WIN) model_fresh();
                        end else begin
                            m_low = 0;
                        end
                        m_wsum = 0; m_wcnt = 0;
                    end
                end
`endif
            end
            default: m_mode = 0;
        endcase
    endtask

    // Inputs are applied at the falling edge; the model moves to the state
    // the rising edge must produce.
    task automatic drive(input bit s, input bit a, input bit v, input int i, input int q);
        bus.start = s; bus.abort = a; bus.sample_valid = v;
        bus.i_in = SW'(i); bus.q_in = SW'(q);
        model_step(s, a, v, i, q);
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic gen(input int pat, input int ch, output int i, output int q);
        case (pat)
            1: begin i = (ch == 2) ? 100 : 10; q = (ch == 2) ? -50 : 10; end
            2: begin i = (ch == 1 || ch == 3) ? 20 : 0; q = i; end
            3: begin i = -2048; q = -2048; end
            default: begin
                if ($urandom_range(0, 7) == 0) begin
                    i = -2048; q = ($urandom_range(0, 1) == 1) ? 2047 : -2048;
                end else begin
                    i = int'($urandom_range(0, 4095)) - 2048;
                    q = int'($urandom_range(0, 4095)) - 2048;
                end
            end
        endcase
    endtask

    task automatic run_scan(input int pat, input bit rnd);
        int i, q, guard;
        bit v, s, a;
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        guard = 0;
        while ((m_mode inside {1, 2, 3}) && guard < 2000) begin
            v = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            gen(pat, m_ch, i, q);
            s = rnd && ($urandom_range(0, 19) == 0);
            a = rnd && ($urandom_range(0, 299) == 0);
            drive(s, a, v, i, q);
            guard++;
        end
        if (guard >= 2000) chk("scan_cycle_budget", 64'(guard), 64'(0));
    endtask

    task automatic run_until(input int ch, input int mode, input int cnt);
        int i, q, guard;
        guard = 0;
        while (!(m_ch == ch && m_mode == mode && m_cnt == cnt) && guard < 2000) begin
            gen(0, m_ch, i, q);
            drive(1'b0, 1'b0, 1'b1, i, q);
            guard++;
        end
        if (guard >= 2000) chk("seek_cycle_budget", 64'(guard), 64'(0));
    endtask

    // Per-cycle comparison, one time unit after the rising edge.
    always @(posedge clk_in) begin
        #1;
        if (chk_en) begin
            chk("busy", 64'(bus.busy), 64'(m_mode inside {1, 2, 3}));
            chk("lock_valid", 64'(bus.lock_valid), 64'(m_mode == 4));
            chk("done", 64'(bus.done), 64'(m_done));
            chk("lo_fre", 64'(bus.lo_fre), 64'(m_lo));
            chk("best_ch", 64'(bus.best_ch), 64'(m_bc));
            chk("best_pwr", 64'(bus.best_pwr), 64'(m_bp));
        end
    end

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int i, q;
        RST = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.sample_valid = 1'b0;
        bus.i_in = '0; bus.q_in = '0;
        model_reset();
        #3 RST = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_lo_fre", 64'(bus.lo_fre), 64'(1000));
        chk("rst_lock_valid", 64'(bus.lock_valid), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_best_pwr", 64'(bus.best_pwr), 64'(0));
        @(negedge clk_in);
        @(negedge clk_in);
        RST = 1'b1;

        // No activity without start (abort and samples are ignored in idle).
        for (int n = 0; n < 6; n++) begin
            gen(0, 0, i, q);
            drive(1'b0, n[0], 1'b1, i, q);
        end

        // Strong channel 2.
        run_scan(1, 1'b0);
        chk("s1_done", 64'(bus.done), 64'(1));
        chk("s1_best_ch", 64'(bus.best_ch), 64'(2));
        chk("s1_best_pwr", 64'(bus.best_pwr), 64'(600));
        chk("s1_lo_fre", 64'(bus.lo_fre), 64'(1200));
        chk("s1_lock_valid", 64'(bus.lock_valid), 64'(1));
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        chk("s1_done_pulse_end", 64'(bus.done), 64'(0));

`ifdef IQ_SCAN_SQUELCH_EN
        for (int n = 0; n < MEAS; n++) drive(1'b0, 1'b0, 1'b1, 0, 0);
        chk("sq_lock_after_1_window", 64'(bus.lock_valid), 64'(1));
        for (int n = 0; n < MEAS; n++) drive(1'b0, 1'b0, 1'b1, 0, 0);
        chk("sq_lock_after_2_windows", 64'(bus.lock_valid), 64'(0));
        chk("sq_busy", 64'(bus.busy), 64'(1));
        chk("sq_lo_fre", 64'(bus.lo_fre), 64'(1000));
        drive(1'b0, 1'b1, 1'b0, 0, 0);
`endif

        // Tie between channels 1 and 3.
        run_scan(2, 1'b0);
        chk("tie_best_ch", 64'(bus.best_ch), 64'(1));
        chk("tie_best_pwr", 64'(bus.best_pwr), 64'(160));

        // Full-scale negative samples on every channel.
        run_scan(3, 1'b0);
        chk("fs_best_ch", 64'(bus.best_ch), 64'(0));
        chk("fs_best_pwr", 64'(bus.best_pwr), 64'(16384));

        // Abort with simultaneous start and sample while measuring channel 1.
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        run_until(1, 2, 1);
        drive(1'b1, 1'b1, 1'b1, 500, 500);
        chk("abort_busy", 64'(bus.busy), 64'(0));
        chk("abort_lock_valid", 64'(bus.lock_valid), 64'(0));
        chk("abort_lo_fre", 64'(bus.lo_fre), 64'(1100));
        for (int n = 0; n < 3; n++) drive(1'b0, 1'b0, 1'b1, 7, 7);

        // Asynchronous reset in the middle of channel 3 settling.
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        run_until(3, 1, 3);
        #2 RST = 1'b0;
        model_reset();
        #1;
        chk("arst_busy", 64'(bus.busy), 64'(0));
        chk("arst_lo_fre", 64'(bus.lo_fre), 64'(1000));
        chk("arst_best_ch", 64'(bus.best_ch), 64'(0));
        chk("arst_best_pwr", 64'(bus.best_pwr), 64'(0));
        chk("arst_done", 64'(bus.done), 64'(0));
        chk("arst_lock_valid", 64'(bus.lock_valid), 64'(0));
        @(negedge clk_in);
        RST = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        chk("rescan_busy", 64'(bus.busy), 64'(1));
        chk("rescan_lo_fre", 64'(bus.lo_fre), 64'(1000));
        run_scan(0, 1'b1);

        // Randomised scans with occasional stray start/abort, then some
        // random activity while locked or idle.
        for (int r = 0; r < 14; r++) begin
            run_scan(0, 1'b1);
            for (int n = 0; n < 6; n++) begin
                gen(($urandom_range(0, 1) == 1) ? 0 : 2, m_ch, i, q);
                drive(1'b0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1), i, q);
            end
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/iq_scan_ctrl.md
IQ_SCAN_CTRL -- requirements
Module: iq_scan_ctrl

Interface
REQ-001 Parameter CH_NUM, default 16: number of channels scanned (2..256).
REQ-002 Parameter PH_BITS, default 32: LO frequency-word width.
REQ-003 Parameter SAMPLE_WIDTH, default 12: signed I/Q sample width.
REQ-004 Parameter START_FRE, default 32'd0: frequency word of channel 0.
REQ-005 Parameter STEP_FRE, default 32'd1000: frequency-word increment per channel.
REQ-006 Parameter SETTLE_CYCLES, default 1024: clk_in cycles discarded after each retune (>=1).
REQ-007 Parameter MEAS_SAMPLES, default 64: valid samples accumulated per channel (power of 2, >=2).
REQ-008 clk_in  input  1  single clock; all logic on its rising edge.
REQ-009 RST  input  1  asynchronous, active-low reset.
REQ-010 start  input  1  single-cycle request to begin a scan.
REQ-011 abort  input  1  single-cycle request to stop a scan.
REQ-012 sample_valid  input  1  qualifies i_in/q_in for one cycle.
REQ-013 i_in, q_in  input  SAMPLE_WIDTH each  signed demodulated I/Q samples.
REQ-014 lo_fre  output  PH_BITS  LO frequency word driving the demodulator.
REQ-015 busy  output  1  high while scanning (TUNE, MEASURE, COMPARE).
REQ-016 done  output  1  one-cycle pulse on entry to LOCK.
REQ-017 lock_valid  output  1  high while in LOCK.
REQ-018 best_ch  output  clog2(CH_NUM)  index of strongest channel.
REQ-019 best_pwr  output  ACC_W  power metric of best_ch; ACC_W = SAMPLE_WIDTH+1+clog2(MEAS_SAMPLES).

Function
REQ-020 FSM states SHALL be IDLE, TUNE, MEASURE, COMPARE, LOCK.
REQ-021 IDLE: start -> TUNE with ch=0, best_pwr=0, best_ch=0; all other inputs ignored.
REQ-022 TUNE: lo_fre = START_FRE + ch*STEP_FRE modulo 2^PH_BITS, registered on the entry edge; after SETTLE_CYCLES cycles -> MEASURE; samples ignored.
REQ-023 MEASURE: on each sample_valid, acc += |i_in|+|q_in| (|-2^(SAMPLE_WIDTH-1)| = 2^(SAMPLE_WIDTH-1), no wrap); after MEAS_SAMPLES valid samples -> COMPARE.
REQ-024 COMPARE (1 cycle): if acc > best_pwr strictly, best_pwr=acc, best_ch=ch; ties keep the lower channel; ch==CH_NUM-1 -> LOCK, else ch+1 -> TUNE.
REQ-025 LOCK: lo_fre = START_FRE + best_ch*STEP_FRE on entry edge; done pulses one cycle; lock_valid=1; start -> TUNE with fresh scan.
REQ-026 start while busy SHALL be ignored.
REQ-027 abort in any state except IDLE -> IDLE next cycle; lock_valid=0, busy=0; lo_fre, best_ch, best_pwr hold; abort wins over simultaneous start or sample_valid.
REQ-028 Accumulator SHALL clear on every TUNE entry; metric width ACC_W guarantees no overflow.

Reset
REQ-029 RST low SHALL immediately force IDLE, lo_fre=START_FRE, busy=0, done=0, lock_valid=0, best_ch=0, best_pwr=0, counters and accumulator 0, regardless of current state.
REQ-030 First state change after RST release SHALL require a start.

Configuration
REQ-031 Macro IQ_SCAN_SQUELCH_EN defined: adds parameter SQ_THRESH (default 0, ACC_W bits) and SQ_WINDOWS (default 4); in LOCK, controller re-measures best_ch continuously in MEAS_SAMPLES windows; SQ_WINDOWS consecutive windows with metric < SQ_THRESH -> lock_valid=0 and automatic rescan (TUNE, ch=0); any window >= threshold resets the count.
REQ-032 Macro undefined: LOCK is static until start, abort or reset; no squelch logic present.

Structure
REQ-033 Shared package iq_scan_pkg SHALL hold the state enumeration, ACC_W function and abs/metric helper.
REQ-034 Sub-module iq_pwr_acc (abs+sum+accumulate+sample count, clear/done handshake) SHALL implement REQ-023/028; FSM stays in iq_scan_ctrl.

Verification (CH_NUM=4, START_FRE=1000, STEP_FRE=100, SETTLE_CYCLES=8, MEAS_SAMPLES=4, SAMPLE_WIDTH=12)
REQ-035 ch2 samples I=100,Q=-50, others I=Q=10 -> done pulse, best_ch=2, best_pwr=600, lo_fre=1200, lock_valid=1.
REQ-036 ch1 and ch3 both I=Q=20, others 0 -> best_ch=1, best_pwr=160.
REQ-037 All samples I=Q=-2048 -> best_pwr=16384, best_ch=0, no wrap.
REQ-038 abort in MEASURE of ch1 with simultaneous start -> IDLE next cycle, busy=0, lo_fre=1100 held.
REQ-039 RST low mid-TUNE of ch3 -> all outputs at reset values same cycle, lo_fre=1000; start after release rescans from ch0.
REQ-040 IQ_SCAN_SQUELCH_EN, SQ_THRESH=100, SQ_WINDOWS=2: after lock drop samples to 0 -> lock_valid falls after 2nd window, busy rises, lo_fre=1000.
